// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation-side UART receiver.
package uart_sim_pkg;

  localparam int UartDataBits = 8;
  localparam int UartMinDiv   = 4;

  typedef enum logic [2:0] {
    RxIdle     = 3'd0,
    RxStart    = 3'd1,
    RxData     = 3'd2,
    RxStop     = 3'd3,
    RxWaitIdle = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port list.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_DEPTH-1:0] r_rdPtr;
  logic [ADDR_DEPTH-1:0] r_wrPtr;
  logic [ADDR_DEPTH:0]   r_count;
  logic                  w_isEmpty;
  logic                  w_passThru;
  logic                  w_doPop;
  logic                  w_doPush;
  logic                  w_unusedTestmode;

  assign w_unusedTestmode = testmode_i;

  assign w_isEmpty  = (r_count == '0);
  assign w_passThru = FALL_THROUGH && w_isEmpty && push_i && pop_i;
  assign full_o     = (r_count == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o    = w_isEmpty && !(FALL_THROUGH && push_i);
  assign usage_o    = r_count[ADDR_DEPTH-1:0];
  assign w_doPop    = pop_i && !w_isEmpty;
  assign w_doPush   = push_i && (!full_o || w_doPop) && !w_passThru;
  assign data_o     = (FALL_THROUGH && w_isEmpty) ? data_i : r_mem[r_rdPtr];

  // Pointer and occupancy bookkeeping plus storage writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= data_i;
        r_wrPtr        <= r_wrPtr + ADDR_DEPTH'(1);
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + ADDR_DEPTH'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (ADDR_DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver that buffers recovered bytes in a FIFO drained by valid/ready.
// Framing errors and dropped bytes are reported through sticky flags.
module uart_rx_sink
  import uart_sim_pkg::*;
#(
  parameter int DivWidth  = 16,
  parameter int FifoDepth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DivWidth-1:0]     baud_div_i,
  input  logic                    rx_i,
  output logic [UartDataBits-1:0] byte_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    frame_err_o,
  output logic                    overflow_o,
  input  logic                    clr_i
);

  localparam int BitIdxW = $clog2(UartDataBits);

  logic                         r_rxMeta;
  logic                         r_rxSync;
  uart_rx_state_e               r_state;
  uart_rx_state_e               w_stateNext;
  logic [DivWidth-1:0]          r_cnt;
  logic [DivWidth-1:0]          w_cntNext;
  logic [BitIdxW-1:0]           r_bitIdx;
  logic [BitIdxW-1:0]           w_bitIdxNext;
  logic [UartDataBits-1:0]      r_shreg;
  logic [UartDataBits-1:0]      w_shregNext;
  logic                         w_push;
  logic                         w_frameErrSet;
  logic                         w_overflowSet;
  logic                         w_fifoPush;
  logic                         w_fifoFull;
  logic                         w_fifoEmpty;
  logic                         w_pop;
  logic                         w_cntZero;
  logic [$clog2(FifoDepth)-1:0] w_unusedUsage;

  assign w_cntZero     = (r_cnt == '0);
  assign busy_o        = (r_state != RxIdle);
  assign valid_o       = !w_fifoEmpty;
  assign w_pop         = valid_o && ready_i;
  assign w_fifoPush    = w_push && (!w_fifoFull || w_pop);
  assign w_overflowSet = w_push && w_fifoFull && !w_pop;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx_i;
      r_rxSync <= r_rxMeta;
    end
  end

  // Receiver state register with its bit timer, bit index and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= RxIdle;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shreg  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitIdxNext;
      r_shreg  <= w_shregNext;
    end
  end

  // Next-state logic; the counter is reloaded on every state entry and each sample lands on cnt == 0.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_bitIdxNext  = r_bitIdx;
    w_shregNext   = r_shreg;
    w_push        = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_state)
      RxIdle: begin
        if (!r_rxSync) begin
          w_stateNext = RxStart;
          w_cntNext   = (baud_div_i >> 1) - DivWidth'(1);
        end
      end
      RxStart: begin
        if (!w_cntZero) begin
          w_cntNext = r_cnt - DivWidth'(1);
        end else if (!r_rxSync) begin
          w_stateNext  = RxData;
          w_cntNext    = baud_div_i - DivWidth'(1);
          w_bitIdxNext = '0;
        end else begin
          w_stateNext = RxIdle;
        end
      end
      RxData: begin
        if (!w_cntZero) begin
          w_cntNext = r_cnt - DivWidth'(1);
        end else begin
          w_shregNext  = {r_rxSync, r_shreg[UartDataBits-1:1]};
          w_cntNext    = baud_div_i - DivWidth'(1);
          w_bitIdxNext = r_bitIdx + BitIdxW'(1);
          if (r_bitIdx == BitIdxW'(UartDataBits - 1)) w_stateNext = RxStop;
        end
      end
      RxStop: begin
        if (!w_cntZero) begin
          w_cntNext = r_cnt - DivWidth'(1);
        end else if (r_rxSync) begin
          w_push      = 1'b1;
          w_stateNext = RxIdle;
        end else begin
          w_frameErrSet = 1'b1;
          w_stateNext   = RxWaitIdle;
        end
      end
      RxWaitIdle: begin
        if (r_rxSync) w_stateNext = RxIdle;
      end
      default: w_stateNext = RxIdle;
    endcase
  end

  // Sticky error flags; a set event in the same cycle as clr_i wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (w_frameErrSet)  frame_err_o <= 1'b1;
      else if (clr_i)     frame_err_o <= 1'b0;
      if (w_overflowSet)  overflow_o  <= 1'b1;
      else if (clr_i)     overflow_o  <= 1'b0;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (UartDataBits),
    .DEPTH        (FifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (~rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (w_fifoFull),
    .empty_o    (w_fifoEmpty),
    .usage_o    (w_unusedUsage),
    .data_i     (r_shreg),
    .push_i     (w_fifoPush),
    .data_o     (byte_o),
    .pop_i      (w_pop)
  );

  // The bit period must be legal and must not move under an active frame.
  assert property (@(posedge clk_i) disable iff (rst_i) baud_div_i >= DivWidth'(UartMinDiv));
  assert property (@(posedge clk_i) disable iff (rst_i) (busy_o && $past(busy_o)) |-> $stable(baud_div_i));

endmodule

// File: tb/tb_uart_rx_sink.sv
// Self-checking bench for uart_rx_sink: drives 8N1 frames and checks against a byte-queue model.
module tb_uart_rx_sink;

  localparam int DivW  = 16;
  localparam int Depth = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [DivW-1:0] baud_div_i;
  logic            rx_i;
  logic [7:0]      byte_o;
  logic            valid_o;
  logic            ready_i;
  logic            busy_o;
  logic            frame_err_o;
  logic            overflow_o;
  logic            clr_i;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Model: bytes the receiver must hold/deliver in order, and the expected sticky flags.
  logic [7:0] expQ[$];
  logic [7:0] popLog[$];
  logic       expFrameErr = 1'b0;
  logic       expOverflow = 1'b0;

  uart_rx_sink #(.DivWidth(DivW), .FifoDepth(Depth)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .baud_div_i  (baud_div_i),
    .rx_i        (rx_i),
    .byte_o      (byte_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .clr_i       (clr_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle valid_o is high the head byte must match the model; a handshake consumes it.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_valid: got byte 0x%0h expected no pending byte", byte_o);
      end else if (byte_o !== expQ[0]) begin
        failures++;
        $display("[TB] FAIL head_byte: got 0x%0h expected 0x%0h", byte_o, expQ[0]);
      end
      if (ready_i) begin
        popLog.push_back(byte_o);
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
    end
  end

  // A frame is complete once its stop bit is on the line; decide what the receiver must do with it.
  task automatic modelDeliver(input logic [7:0] data, input logic stopBit, input logic popAtPush);
    if (!stopBit) expFrameErr = 1'b1;
    else if (expQ.size() < Depth || popAtPush) expQ.push_back(data);
    else expOverflow = 1'b1;
  endtask

  task automatic driveBit(input logic v);
    rx_i = v;
    repeat (int'(baud_div_i)) @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic popAtPush);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    modelDeliver(data, stopBit, popAtPush);
    driveBit(stopBit);
  endtask

  task automatic waitFirstValid(input int t0);
    int n = 0;
    while (!valid_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("first_valid_latency", 32'(cycle - t0), 32'd79);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((valid_o || expQ.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    checkOutput("drain_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_frame_err"}, 32'(frame_err_o), 32'(expFrameErr));
    checkOutput({tag, "_overflow"}, 32'(overflow_o), 32'(expOverflow));
  endtask

  task automatic checkResetValues();
    @(negedge clk_i);
    checkOutput("rst_byte", 32'(byte_o), 32'h00);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err_o), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
  endtask

  task automatic pulseClear();
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    expFrameErr = 1'b0;
    expOverflow = 1'b0;
  endtask

  // Hard stop in case a directed wait never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int t0;
    rst_i      = 1'b1;
    rx_i       = 1'b1;
    ready_i    = 1'b0;
    clr_i      = 1'b0;
    baud_div_i = 16'd8;
    repeat (2) @(posedge clk_i);
    checkResetValues();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;

    $display("[TB] back-to-back 0x55, 0xA3 at div 8");
    ready_i = 1'b1;
    popLog.delete();
    t0 = cycle;
    fork
      begin
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
      end
      waitFirstValid(t0);
    join
    waitDrain();
    checkOutput("t1_count", 32'(popLog.size()), 32'd2);
    if (popLog.size() == 2) begin
      checkOutput("t1_byte0", 32'(popLog[0]), 32'h55);
      checkOutput("t1_byte1", 32'(popLog[1]), 32'hA3);
    end
    checkFlags("t1");

    $display("[TB] two-cycle glitch at div 16");
    baud_div_i = 16'd16;
    @(posedge clk_i);
    #1;
    rx_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("glitch_busy", 32'(busy_o), 32'd1);
    repeat (30) @(posedge clk_i);
    #1;
    checkOutput("glitch_idle", 32'(busy_o), 32'd0);
    checkOutput("glitch_valid", 32'(valid_o), 32'd0);
    checkFlags("glitch");
    checkOutput("glitch_frame_err_lit", 32'(frame_err_o), 32'd0);
    baud_div_i = 16'd8;
    @(posedge clk_i);
    #1;

    $display("[TB] framing error then break then 0x7E");
    popLog.delete();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("ferr_set_lit", 32'(frame_err_o), 32'd1);
    applyStimulus(8'h7E, 1'b1, 1'b0);
    waitDrain();
    checkOutput("ferr_count", 32'(popLog.size()), 32'd1);
    if (popLog.size() == 1) checkOutput("ferr_byte", 32'(popLog[0]), 32'h7E);
    checkFlags("ferr");
    pulseClear();
    checkOutput("ferr_cleared", 32'(frame_err_o), 32'd0);

    $display("[TB] overflow with five bytes into depth four");
    popLog.delete();
    ready_i = 1'b0;
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    checkFlags("ovf");
    checkOutput("ovf_set_lit", 32'(overflow_o), 32'd1);
    ready_i = 1'b1;
    waitDrain();
    checkOutput("ovf_count", 32'(popLog.size()), 32'd4);
    for (int i = 0; i < popLog.size() && i < 4; i++)
      checkOutput("ovf_order", 32'(popLog[i]), 32'(i + 1));
    pulseClear();
    checkOutput("ovf_cleared", 32'(overflow_o), 32'd0);

    $display("[TB] pop coinciding with push into a full FIFO");
    popLog.delete();
    ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 1'b1, 1'b0);
    fork
      applyStimulus(8'h05, 1'b1, 1'b1);
      begin
        repeat (78) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
      end
    join
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("fullpop_no_ovf", 32'(overflow_o), 32'd0);
    ready_i = 1'b1;
    waitDrain();
    checkOutput("fullpop_count", 32'(popLog.size()), 32'd5);
    if (popLog.size() == 5) checkOutput("fullpop_last", 32'(popLog[4]), 32'h05);
    checkFlags("fullpop");

    $display("[TB] reset during DATA of 0xF0 then 0x0F");
    popLog.delete();
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b0);
    checkOutput("mid_frame_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    expQ.delete();
    expFrameErr = 1'b0;
    expOverflow = 1'b0;
    checkResetValues();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    applyStimulus(8'h0F, 1'b1, 1'b0);
    waitDrain();
    checkOutput("rst_count", 32'(popLog.size()), 32'd1);
    if (popLog.size() == 1) checkOutput("rst_byte_rx", 32'(popLog[0]), 32'h0F);
    checkFlags("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sink.md
# uart_rx_sink

Simulation-side 8N1 UART receiver for the Verilator top. It samples the SoC's `uart_tx_o` line, recovers bytes at a runtime-programmable bit period, and buffers them in a FIFO. The C++ harness drains that FIFO through a valid/ready port. It is the receiving end of the SoC UART transmit path, and it reports framing errors and overflow as sticky flags.

## Interface
Parameters:
- `DivWidth`, default 16: width of the bit-period divisor.
- `FifoDepth`, default 16: number of received-byte entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1: system clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `baud_div_i`  in  DivWidth: clock cycles per UART bit. Must be ≥4 and must stay static while `busy_o` is high.
- `rx_i`  in  1: serial line, connected to the SoC's `uart_tx_o`. Idle level is 1.
- `byte_o`  out  8: head-of-FIFO byte.
- `valid_o`  out  1: FIFO not empty.
- `ready_i`  in  1: consumer accept. A pop happens when `valid_o && ready_i`.
- `busy_o`  out  1: the FSM is in any state other than IDLE.
- `frame_err_o`  out  1: sticky; set when a stop bit is sampled as 0.
- `overflow_o`  out  1: sticky; set when a byte is dropped because the FIFO is full.
- `clr_i`  in  1: synchronous clear of both sticky flags.

## Operation
- `rx_i` passes through a 2-flop synchronizer (`rx_s`); the synchronizer flops reset to 1.
- A single down-counter `cnt` (DivWidth bits) paces the bit timing. It is reloaded on every state entry. A bit is sampled in the cycle `cnt == 0`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_s == 0`, go to START and load `cnt = (baud_div_i >> 1) - 1`.
  - START: at `cnt == 0`, sample `rx_s`.
    - `rx_s == 0`: go to DATA, load `cnt = baud_div_i - 1`, clear `bitidx`.
    - `rx_s == 1`: glitch; return to IDLE with no flag set.
  - DATA: at each `cnt == 0`, shift `rx_s` into `shreg[7]` (the byte is sent LSB first), reload the counter, and increment `bitidx`. After the 8th sample, go to STOP and load `cnt = baud_div_i - 1`.
  - STOP: at `cnt == 0`, sample `rx_s`.
    - `rx_s == 1`: push `shreg` to the FIFO and go to IDLE.
    - `rx_s == 0`: discard the byte, set `frame_err_o`, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s == 1`, then go to IDLE. This prevents a break condition from being read as new start bits.
- FIFO full at push time: drop the byte and set `overflow_o`. FIFO contents are unchanged.
- Push and pop in the same cycle are both honoured, including when the FIFO is full: pop-while-full plus push stores the byte.
- Sticky flags: if `clr_i` and a set event occur in the same cycle, set wins.
- Reset mid-frame: the FSM returns to IDLE and any partial byte is lost. After reset, the block re-synchronizes on the next low level of `rx_s`.

## Timing
- Reset values:
  - `byte_o` = 0x00, `valid_o` = 0, `busy_o` = 0, `frame_err_o` = 0, `overflow_o` = 0.
  - FSM = IDLE, `cnt` = 0, `shreg` = 0x00.
- Sample points land at bit centres, offset by the 2-cycle synchronizer delay.
- Latency: the stop-bit sample cycle pushes; `valid_o` rises the next cycle (non-fall-through FIFO). From the start-bit falling edge on `rx_i` to `valid_o`, the latency is 2 + `baud_div_i/2` + 9·`baud_div_i` + 1 cycles.
- `byte_o` is stable while `valid_o && !ready_i`.
- A pop updates `byte_o` and `valid_o` in the next cycle.
- `busy_o` is combinational from the FSM state register.
- Back-to-back frames: after the IDLE state is re-entered at mid-stop-bit, a start bit immediately following the stop bit is detected correctly.

## Structure
- Package `uart_sim_pkg` holds:
  - `uart_rx_state_e` (the 3-bit enum of the five states above);
  - `UartDataBits = 8`;
  - `UartMinDiv = 4`.
- Sub-module: `fifo_v3` from common_cells, configured as:
  - `FALL_THROUGH = 0`, `DATA_WIDTH = 8`, `DEPTH = FifoDepth`;
  - `rst_ni = ~rst_i`, `flush_i = 0`, `testmode_i = 0`.
- Add an assertion (simulation only): `baud_div_i >= UartMinDiv`, and `baud_div_i` does not change while `busy_o` is high.

## Test plan
- `baud_div_i` = 8, send 0x55 then 0xA3 back-to-back with `ready_i` = 1 → `byte_o` = 0x55 then 0xA3, one `valid_o` pulse each, no flags. The first `valid_o` appears exactly 2 + 4 + 72 + 1 = 79 cycles after the start edge.
- 2-cycle low glitch on `rx_i` with `baud_div_i` = 16 → FSM returns to IDLE, `valid_o` stays 0, `frame_err_o` stays 0.
- 0x3C sent with stop bit forced to 0, then the line is held low for 40 cycles, then 0x7E sent normally → `frame_err_o` = 1, only 0x7E is received. `clr_i` then clears `frame_err_o` to 0.
- `FifoDepth` = 4, `ready_i` = 0, send 5 bytes 0x01–0x05 → 0x01–0x04 are retained in order and `overflow_o` = 1. Raising `ready_i` drains 4 bytes, then `valid_o` = 0.
- FIFO full, and `ready_i` pulses in the same cycle as the 5th byte's stop sample → no overflow; the drained sequence ends with that byte.
- Assert `rst_i` during DATA of 0xF0, then release it and send 0x0F → only 0x0F is received; all outputs equal their reset values during reset.
